// File: rtl/adc_avg_sequencer.sv
// rtl/adc_avg_sequencer.sv - periodic ADC request sequencer with 2^LOG2_N rounded averaging and timeout
module adc_avg_sequencer #(
    parameter int DATA_W  = 12,
    parameter int LOG2_N  = 3,
    parameter int PERIOD  = 50000,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DATA_W-1:0] ad_in,
    input  logic              flag,
    output logic              convert,
    output logic [DATA_W-1:0] avg_out,
    output logic              avg_valid,
    output logic              busy,
    output logic              timeout_err
);
    localparam int ACC_W = DATA_W + LOG2_N;
    localparam int PER_W = $clog2(PERIOD);
    localparam int TMO_W = $clog2(TIMEOUT);
    localparam logic [PER_W-1:0]  PER_LAST = PER_W'(PERIOD - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [LOG2_N-1:0] CNT_LAST = '1;
    localparam logic [ACC_W-1:0]  HALF     = ACC_W'(2 ** (LOG2_N - 1));

    typedef enum logic [1:0] {S_TICK, S_REQ, S_WAIT, S_OUT} state_t;

    state_t              state_q, state_d;
    logic [PER_W-1:0]    per_q, per_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [LOG2_N-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   avg_q, avg_d;
    logic                convert_q, valid_q, valid_d, busy_q, err_q, err_d;
    logic [ACC_W-1:0]    rounded;

    // Sum of N full-scale samples plus N/2 still fits in ACC_W bits.
    assign rounded = acc_q + HALF;

    always_comb begin
        state_d = state_q;
        per_d   = per_q;
        tmo_d   = tmo_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        avg_d   = avg_q;
        valid_d = 1'b0;
        err_d   = err_q;
        case (state_q)
            S_TICK: begin
                if (!enable) begin
                    per_d = '0;
                end else if (per_q == PER_LAST) begin
                    per_d   = '0;
                    state_d = S_REQ;
                end else begin
                    per_d = per_q + PER_W'(1);
                end
            end
            S_REQ: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A flag on the final wait cycle still counts as a completed conversion.
                if (flag) begin
                    acc_d   = acc_q + ACC_W'(ad_in);
                    cnt_d   = cnt_q + LOG2_N'(1);
                    state_d = (cnt_q == CNT_LAST) ? S_OUT : S_TICK;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_TICK;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_OUT: begin
                avg_d   = rounded[ACC_W-1:LOG2_N];
                valid_d = 1'b1;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = S_TICK;
            end
            default: state_d = S_TICK;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_TICK;
            per_q     <= '0;
            tmo_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            avg_q     <= '0;
            convert_q <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            per_q     <= per_d;
            tmo_q     <= tmo_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            avg_q     <= avg_d;
            convert_q <= (state_d == S_REQ);
            valid_q   <= valid_d;
            busy_q    <= (state_d != S_TICK);
            err_q     <= err_d;
        end
    end

    assign convert     = convert_q;
    assign avg_out     = avg_q;
    assign avg_valid   = valid_q;
    assign busy        = busy_q;
    assign timeout_err = err_q;
endmodule
